// File: rtl/ps2_kbd_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard-to-ASCII slice.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

endpackage

// File: rtl/ps2_scan2asc.sv
// Combinational set-2 scan code to ASCII translation (letters, digits,
// space, enter, backspace). Extended codes and unknown codes give 8'h00.
module ps2_scan2asc (
  input  logic [7:0] scancode,
  input  logic       shift,
  input  logic       ext,
  output logic [7:0] ascii
);

  logic [7:0] base;

  // Lookup of the unshifted character, then upper-casing of letters.
  always_comb begin
    base = 8'h00;
    unique case (scancode)
      8'h1C: base = "a";  8'h32: base = "b";  8'h21: base = "c";
      8'h23: base = "d";  8'h24: base = "e";  8'h2B: base = "f";
      8'h34: base = "g";  8'h33: base = "h";  8'h43: base = "i";
      8'h3B: base = "j";  8'h42: base = "k";  8'h4B: base = "l";
      8'h3A: base = "m";  8'h31: base = "n";  8'h44: base = "o";
      8'h4D: base = "p";  8'h15: base = "q";  8'h2D: base = "r";
      8'h1B: base = "s";  8'h2C: base = "t";  8'h3C: base = "u";
      8'h2A: base = "v";  8'h1D: base = "w";  8'h22: base = "x";
      8'h35: base = "y";  8'h1A: base = "z";
      8'h45: base = "0";  8'h16: base = "1";  8'h1E: base = "2";
      8'h26: base = "3";  8'h25: base = "4";  8'h2E: base = "5";
      8'h36: base = "6";  8'h3D: base = "7";  8'h3E: base = "8";
      8'h46: base = "9";
      8'h29: base = 8'h20;
      8'h5A: base = 8'h0D;
      8'h66: base = 8'h08;
      default: base = 8'h00;
    endcase

    ascii = base;
    if (ext)
      ascii = 8'h00;
    else if (shift && base >= "a" && base <= "z")
      ascii = base - 8'h20;
  end

endmodule

// File: rtl/ps2_kbd_ascii.sv
// PS/2 keyboard receiver, make/break decoder and ASCII FIFO.
// Optional receiver watchdog enabled by defining PS2_TIMEOUT_EN.
module ps2_kbd_ascii
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] asc,
  output logic       ready,
  output logic       overflow,
  output logic       parity_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ps2_kbd_ascii: FIFO_DEPTH must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [1:0] clk_sync, data_sync;
  logic       clk_prev, fall, rx_bit;

  rx_state_t  state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic       par_q, par_n, stb_n, perr_n, byte_stb;

  logic       shift_f, brk_f, ext_f;
  logic [7:0] xlat;
  logic       push_valid;
  logic [7:0] push_data;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, pop, wr;

  // Two-flop synchronisers plus a delayed copy of ps2_clk for edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[1];
  assign rx_bit = data_sync[1];

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          timed_out;

  // Watchdog: cycles since the last ps2_clk falling edge, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (fall)
      to_cnt <= '0;
    else if (to_cnt != TW'(TIMEOUT_CYCLES))
      to_cnt <= to_cnt + 1'b1;
  end

  assign timed_out = (state != ST_IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES));
`endif

  // Receiver state register; strobes are registered so they appear the
  // cycle after the stop bit is sampled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_q      <= 1'b0;
      byte_stb   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      par_q      <= par_n;
      byte_stb   <= stb_n;
      parity_err <= perr_n;
    end
  end

  // Receiver next-state: advances only on a detected ps2_clk falling edge.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par_q;
    stb_n     = 1'b0;
    perr_n    = 1'b0;
    if (fall) begin
      unique case (state)
        ST_IDLE: begin
          if (!rx_bit) begin
            state_n   = ST_DATA;
            bit_cnt_n = '0;
          end
        end
        ST_DATA: begin
          shreg_n   = {rx_bit, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state_n = ST_PARITY;
        end
        ST_PARITY: begin
          par_n   = rx_bit;
          state_n = ST_STOP;
        end
        ST_STOP: begin
          if (rx_bit && ^{shreg, par_q})
            stb_n = 1'b1;
          else
            perr_n = 1'b1;
          state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
`ifdef PS2_TIMEOUT_EN
    else if (timed_out) begin
      state_n = ST_IDLE;
    end
`endif
  end

  ps2_scan2asc u_scan2asc (
    .scancode (shreg),
    .shift    (shift_f),
    .ext      (ext_f),
    .ascii    (xlat)
  );

  // Make/break decoder; translated characters are staged one cycle
  // before entering the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_f    <= 1'b0;
      brk_f      <= 1'b0;
      ext_f      <= 1'b0;
      push_valid <= 1'b0;
      push_data  <= '0;
    end else begin
      push_valid <= 1'b0;
      if (byte_stb) begin
        if (shreg == SC_EXT) begin
          ext_f <= 1'b1;
        end else if (shreg == SC_BRK) begin
          brk_f <= 1'b1;
        end else if (brk_f) begin
          if (shreg == SC_LSHIFT || shreg == SC_RSHIFT)
            shift_f <= 1'b0;
          brk_f <= 1'b0;
          ext_f <= 1'b0;
        end else begin
          if (shreg == SC_LSHIFT || shreg == SC_RSHIFT)
            shift_f <= 1'b1;
          else if (xlat != 8'h00) begin
            push_valid <= 1'b1;
            push_data  <= xlat;
          end
          ext_f <= 1'b0;
        end
      end
    end
  end

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign pop   = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr    = push_valid & (~full | pop);

  // FIFO storage; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr] <= push_data;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (wr && !pop)
        count <= count + 1'b1;
      else if (pop && !wr)
        count <= count - 1'b1;
      if (push_valid && !wr)
        overflow <= 1'b1;
      else if (pop)
        overflow <= 1'b0;
    end
  end

  assign ready = ~empty;
  assign asc   = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_ps2_kbd_ascii.sv
// Directed self-checking bench for ps2_kbd_ascii. The watchdog scenario is
// compiled in when PS2_TIMEOUT_EN is defined.
module tb_ps2_kbd_ascii;

  localparam int TO_CYC = 200;

  logic       clk = 1'b0;
  logic       rst_n, ps2_clk, ps2_data, rd_en;
  logic [7:0] asc;
  logic       ready, overflow, parity_err;

  int total = 0;
  int bad   = 0;
  int perr_cnt = 0;
  int perr_before;

  ps2_kbd_ascii #(
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd_en      (rd_en),
    .asc        (asc),
    .ready      (ready),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n === 1'b1 && parity_err === 1'b1)
      perr_cnt++;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One PS/2 bit; with pop_sync, rd_en is raised in the cycle the FIFO
  // write lands (fourth negedge after ps2_clk falls on the stop bit).
  task automatic ps2_bit(input logic v, input bit pop_sync);
    @(negedge clk) ps2_data = v;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    if (pop_sync) begin
      repeat (4) @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      repeat (3) @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par, input bit pop_sync);
    logic par;
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      ps2_bit(b[i], 1'b0);
    ps2_bit(par, 1'b0);
    ps2_bit(1'b1, pop_sync);
    repeat (10) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_asc", asc, 8'h00);
    chk("rst_ready", {7'd0, ready}, 8'h00);
    chk("rst_ovf", {7'd0, overflow}, 8'h00);
    chk("rst_perr", {7'd0, parity_err}, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // press/release 'a'
    send(8'h1C, 0, 0); send(8'hF0, 0, 0); send(8'h1C, 0, 0);
    chk("a_ready", {7'd0, ready}, 8'h01);
    chk("a_asc", asc, 8'h61);
    pop();
    chk("a_ready_after", {7'd0, ready}, 8'h00);
    chk("a_asc_after", asc, 8'h00);

    // shift + a, release shift, a
    send(8'h12, 0, 0); send(8'h1C, 0, 0); send(8'hF0, 0, 0);
    send(8'h12, 0, 0); send(8'h1C, 0, 0);
    chk("sh_first", asc, 8'h41);
    pop();
    chk("sh_second", asc, 8'h61);
    pop();
    chk("sh_empty", {7'd0, ready}, 8'h00);

    // bad parity, then a good '1'
    perr_before = perr_cnt;
    send(8'h16, 1, 0);
    chk("par_pulses", 8'(perr_cnt - perr_before), 8'h01);
    chk("par_nopush", {7'd0, ready}, 8'h00);
    send(8'h16, 0, 0);
    chk("par_recover", asc, 8'h31);
    pop();

    // overflow: nine makes '1'..'9'
    send(8'h16, 0, 0); send(8'h1E, 0, 0); send(8'h26, 0, 0);
    send(8'h25, 0, 0); send(8'h2E, 0, 0); send(8'h36, 0, 0);
    send(8'h3D, 0, 0); send(8'h3E, 0, 0); send(8'h46, 0, 0);
    chk("ovf_set", {7'd0, overflow}, 8'h01);
    chk("ovf_head", asc, 8'h31);
    pop();
    chk("ovf_clr", {7'd0, overflow}, 8'h00);
    chk("ovf_head2", asc, 8'h32);
    send(8'h45, 0, 0);
    chk("full_again_ovf", {7'd0, overflow}, 8'h00);
    send(8'h1C, 0, 1);
    chk("pushpop_ovf", {7'd0, overflow}, 8'h00);
    chk("pushpop_head", asc, 8'h33);
    chk("drain0", asc, 8'h33); pop();
    chk("drain1", asc, 8'h34); pop();
    chk("drain2", asc, 8'h35); pop();
    chk("drain3", asc, 8'h36); pop();
    chk("drain4", asc, 8'h37); pop();
    chk("drain5", asc, 8'h38); pop();
    chk("drain6", asc, 8'h30); pop();
    chk("drain7", asc, 8'h61); pop();
    chk("drain_empty", {7'd0, ready}, 8'h00);
    chk("drain_asc0", asc, 8'h00);

    // reset mid-frame, then space
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0); ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b1 == 1'b0); ps2_bit(1'b1, 1'b0);
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    perr_before = perr_cnt;
    send(8'h29, 0, 0);
    chk("midrst_asc", asc, 8'h20);
    chk("midrst_perr", 8'(perr_cnt - perr_before), 8'h00);
    pop();
    chk("midrst_single", {7'd0, ready}, 8'h00);

`ifdef PS2_TIMEOUT_EN
    perr_before = perr_cnt;
    ps2_bit(1'b0, 1'b0);
    repeat (TO_CYC + 50) @(negedge clk);
    chk("to_nopush", {7'd0, ready}, 8'h00);
    chk("to_noperr", 8'(perr_cnt - perr_before), 8'h00);
    send(8'h5A, 0, 0);
    chk("to_enter", asc, 8'h0D);
    pop();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_ascii.md
PS2_KBD_ASCII -- requirements
Module: ps2_kbd_ascii

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of buffered ASCII characters (power of two, 2..64).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, receiver watchdog limit in clk cycles.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port ps2_clk  input  1  keyboard clock, asynchronous.
REQ-006 SHALL have port ps2_data  input  1  keyboard data, asynchronous.
REQ-007 SHALL have port rd_en  input  1  CPU pop strobe for the memory-mapped keyboard register.
REQ-008 SHALL have port asc  output  8  ASCII code at FIFO head, 8'h00 when empty.
REQ-009 SHALL have port ready  output  1  FIFO non-empty.
REQ-010 SHALL have port overflow  output  1  sticky: a character was dropped.
REQ-011 SHALL have port parity_err  output  1  one-cycle pulse on a bad frame.

Function
REQ-012 SHALL synchronise ps2_clk and ps2_data through two flops and detect a ps2_clk falling edge from the synchronised value and its previous value.
REQ-013 SHALL run receiver FSM IDLE->DATA->PARITY->STOP->IDLE, advancing only on detected falling edges.
REQ-014 IDLE: ps2_data=0 enters DATA with bit counter 0; ps2_data=1 stays IDLE.
REQ-015 DATA: shift bits LSB-first; after the 8th bit enter PARITY.
REQ-016 PARITY: latch the bit; enter STOP.
REQ-017 STOP: if stop bit is 1 and data+parity has odd ones, emit a byte strobe the next cycle; otherwise pulse parity_err and emit nothing; always return to IDLE.
REQ-018 Decoder: byte 8'hE0 sets ext flag; byte 8'hF0 sets brk flag; neither produces output.
REQ-019 Decoder: any other byte with brk set is a release: clear shift if 8'h12 or 8'h59; clear brk and ext; no output.
REQ-020 Decoder: any other byte with brk clear is a make: 8'h12/8'h59 set shift; else translate; clear ext.
REQ-021 Translation SHALL cover set-2 letters, digits 0-9, space (8'h29->8'h20), enter (8'h5A->8'h0D), backspace (8'h66->8'h08); letters upper-case when shift set, lower-case otherwise; ext set or untranslated code yields 8'h00, which is not pushed.
REQ-022 Non-zero ASCII SHALL be pushed into the FIFO one cycle after the byte strobe; ready rises the following cycle.
REQ-023 rd_en with ready high SHALL pop the head in that cycle; rd_en with FIFO empty SHALL be ignored.
REQ-024 Push with FIFO full and no pop SHALL drop the new character and set overflow; push and pop together when full SHALL both succeed without overflow.
REQ-025 Push and rd_en together when empty SHALL push only; ready rises the next cycle.
REQ-026 overflow SHALL clear on the first accepted pop after it was set.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width SHALL be clog2(FIFO_DEPTH)+1.

Reset
REQ-028 rst_n low at a clock edge SHALL force: FSM IDLE, bit counter 0, shift/brk/ext clear, FIFO empty, asc=8'h00, ready=0, overflow=0, parity_err=0, synchroniser flops to 1.
REQ-029 Reset mid-frame SHALL discard the partial frame; the next start bit SHALL be received normally.

Configuration
REQ-030 With PS2_TIMEOUT_EN defined, a counter SHALL reset to 0 on every falling edge; if the FSM is not IDLE and the counter reaches TIMEOUT_CYCLES, the FSM SHALL return to IDLE, discarding the frame without parity_err.
REQ-031 Without PS2_TIMEOUT_EN, no watchdog logic SHALL exist and a stalled frame SHALL remain pending until completed or reset.

Structure
REQ-032 Package ps2_kbd_pkg SHALL hold the receiver state enum and the constants for the 8'hE0, 8'hF0, 8'h12 and 8'h59 codes.
REQ-033 Translation SHALL be a combinational sub-module ps2_scan2asc (scancode, shift, ext -> ascii); the FIFO stays inline.

Verification
REQ-034 Frame 8'h1C (press a), then 8'hF0 8'h1C -> exactly one entry 8'h61; ready=1; rd_en -> ready=0, asc=8'h00.
REQ-035 8'h12, 8'h1C, 8'hF0 8'h12, 8'h1C -> entries 8'h41 then 8'h61 in order.
REQ-036 Frame 8'h16 with wrong parity bit -> one parity_err pulse, no push; following valid 8'h16 -> 8'h31.
REQ-037 Nine make codes with no reads (FIFO_DEPTH=8) -> 8 entries, overflow=1, 9th dropped; one rd_en -> overflow=0; push and rd_en in the same cycle when full -> count stays 8, overflow stays 0.
REQ-038 rst_n low after 4 data bits, then full frame 8'h29 -> single entry 8'h20.
REQ-039 With PS2_TIMEOUT_EN: start bit then ps2_clk held high for TIMEOUT_CYCLES -> FSM IDLE, no push, no parity_err; next frame 8'h5A -> 8'h0D.
